// File: rtl/truth_table_scanner_pkg.sv
// Shared types and sizes for the truth-table scanner and its compare unit.
package truth_table_scanner_pkg;

    localparam int NUM_VECTORS = 16;
    localparam int INDEX_W     = 4;
    localparam int COUNT_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/truth_table_scanner_compare.sv
// Mismatch accumulator: counts failing vectors and remembers the first one.
module tt_compare
    import truth_table_scanner_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               strobe_i,
    input  logic [INDEX_W-1:0] index_i,
    input  logic               s_in_i,
    input  logic               exp_bit_i,
    output logic [COUNT_W-1:0] err_count_o,
    output logic               err_valid_o,
    output logic [INDEX_W-1:0] first_err_o,
    output logic               mismatch_o
);

    logic [COUNT_W-1:0] err_count_q, err_count_d;
    logic               err_valid_q, err_valid_d;
    logic [INDEX_W-1:0] first_err_q, first_err_d;

    assign mismatch_o = strobe_i && (s_in_i != exp_bit_i);

    always_comb begin
        err_count_d = err_count_q;
        err_valid_d = err_valid_q;
        first_err_d = first_err_q;
        if (clear_i) begin
            err_count_d = '0;
            err_valid_d = 1'b0;
            first_err_d = '0;
        end else if (mismatch_o) begin
            err_count_d = err_count_q + 1'b1;
            err_valid_d = 1'b1;
            // Only the lowest failing index is kept; vectors arrive in ascending order.
            if (!err_valid_q) first_err_d = index_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_count_q <= '0;
            err_valid_q <= 1'b0;
            first_err_q <= '0;
        end else begin
            err_count_q <= err_count_d;
            err_valid_q <= err_valid_d;
            first_err_q <= first_err_d;
        end
    end

    assign err_count_o = err_count_q;
    assign err_valid_o = err_valid_q;
    assign first_err_o = first_err_q;

endmodule

// File: rtl/truth_table_scanner.sv
// Walks all 16 input vectors of an external 4-input function, captures its
// response into a truth table and compares it against a latched golden table.
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [15:0]        expected_i,
    input  logic               s_in_i,
    output logic               a_o,
    output logic               b_o,
    output logic               c_o,
    output logic               d_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [15:0]        table_o,
    output logic               pass_o,
    output logic [COUNT_W-1:0] err_count_o,
    output logic               err_valid_o,
    output logic [INDEX_W-1:0] first_err_o
);

    localparam logic [3:0]         WIN_LAST = 4'(WAIT_CYCLES);
    localparam logic [INDEX_W-1:0] IDX_LAST = INDEX_W'(NUM_VECTORS - 1);

    state_e             state_q;
    logic [INDEX_W-1:0] idx_q;
    logic [3:0]         cnt_q;
    logic [15:0]        exp_q;
    logic [15:0]        table_q;
    logic               pass_q;

    logic               accept;
    logic               strobe;
    logic               mismatch;

    assign accept = (state_q == ST_IDLE) && start_i;
    // Sample on the last cycle of each vector window.
    assign strobe = (state_q == ST_DRIVE) && (cnt_q == WIN_LAST);

    tt_compare u_cmp (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (accept),
        .strobe_i   (strobe),
        .index_i    (idx_q),
        .s_in_i     (s_in_i),
        .exp_bit_i  (exp_q[idx_q]),
        .err_count_o(err_count_o),
        .err_valid_o(err_valid_o),
        .first_err_o(first_err_o),
        .mismatch_o (mismatch)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            table_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        exp_q   <= expected_i;
                        table_q <= '0;
                        pass_q  <= 1'b0;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (strobe) begin
                        table_q[idx_q] <= s_in_i;
                        cnt_q          <= '0;
                        if (idx_q == IDX_LAST) begin
                            // The last sample's mismatch is not in err_count yet.
                            pass_q  <= (err_count_o == '0) && !mismatch;
                            state_q <= ST_DONE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o  = (state_q == ST_DRIVE);
    assign done_o  = (state_q == ST_DONE);
    assign a_o     = busy_o && idx_q[3];
    assign b_o     = busy_o && idx_q[2];
    assign c_o     = busy_o && idx_q[1];
    assign d_o     = busy_o && idx_q[0];
    assign table_o = table_q;
    assign pass_o  = pass_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Drives two scanners (WAIT_CYCLES=1 and 0) against a behavioural 4-input function.
module tb_truth_table_scanner;

    typedef struct {
        logic [15:0] model;
        logic [15:0] expv;
        logic [15:0] tbl;
        logic        pass;
        logic [4:0]  cnt;
        logic        vld;
        logic [3:0]  first;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] expected = 16'h0;
    logic [15:0] model = 16'h0;

    logic        a1, b1, c1, d1, busy1, done1, pass1, vld1, s1;
    logic [15:0] tbl1;
    logic [4:0]  cnt1;
    logic [3:0]  first1;
    logic        a0, b0, c0, d0, busy0, done0, pass0, vld0, s0;
    logic [15:0] tbl0;
    logic [4:0]  cnt0;
    logic [3:0]  first0;

    int n_chk = 0;
    int n_fail = 0;
    vec_t vecs[7];

    always #5 clk = ~clk;

    assign s1 = model[{a1, b1, c1, d1}];
    assign s0 = model[{a0, b0, c0, d0}];

    truth_table_scanner #(.WAIT_CYCLES(1)) dut1 (
        .clk_i(clk), .reset_i(reset), .start_i(start), .expected_i(expected), .s_in_i(s1),
        .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1), .busy_o(busy1), .done_o(done1),
        .table_o(tbl1), .pass_o(pass1), .err_count_o(cnt1), .err_valid_o(vld1),
        .first_err_o(first1)
    );

    truth_table_scanner #(.WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .reset_i(reset), .start_i(start), .expected_i(expected), .s_in_i(s0),
        .a_o(a0), .b_o(b0), .c_o(c0), .d_o(d0), .busy_o(busy0), .done_o(done0),
        .table_o(tbl0), .pass_o(pass0), .err_count_o(cnt0), .err_valid_o(vld0),
        .first_err_o(first0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Start both scanners together; optionally pulse start and flip expected mid-scan.
    task automatic run_scan(input vec_t v, input bit disturb);
        int lat1, lat0, nd1, nd0;
        lat1 = 0; lat0 = 0; nd1 = 0; nd0 = 0;
        @(negedge clk);
        model = v.model; expected = v.expv; start = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (disturb && (n % 4 == 0) && n <= 12) start = 1'b1;
            if (disturb && n == 6) expected = ~v.expv;
            if (n <= 16) chk("w0_vector", {28'd0, a0, b0, c0, d0}, 32'(n - 1));
            if (n <= 32) chk("w1_vector", {28'd0, a1, b1, c1, d1}, 32'((n - 1) / 2));
            if (done1) begin
                nd1++;
                if (lat1 == 0) lat1 = n;
                chk("w1_pass_at_done", {31'd0, pass1}, {31'd0, v.pass});
                chk("w1_busy_at_done", {31'd0, busy1}, 32'd0);
            end
            if (done0) begin
                nd0++;
                if (lat0 == 0) lat0 = n;
            end
        end
        chk("w1_done_latency", 32'(lat1), 32'd33);
        chk("w0_done_latency", 32'(lat0), 32'd17);
        chk("w1_done_pulses", 32'(nd1), 32'd1);
        chk("w0_done_pulses", 32'(nd0), 32'd1);
        chk("w1_table", {16'd0, tbl1}, {16'd0, v.tbl});
        chk("w1_pass", {31'd0, pass1}, {31'd0, v.pass});
        chk("w1_err_count", {27'd0, cnt1}, {27'd0, v.cnt});
        chk("w1_err_valid", {31'd0, vld1}, {31'd0, v.vld});
        chk("w1_first_err", {28'd0, first1}, {28'd0, v.first});
        chk("w0_table", {16'd0, tbl0}, {16'd0, v.tbl});
        chk("w0_pass", {31'd0, pass0}, {31'd0, v.pass});
        chk("w0_err_count", {27'd0, cnt0}, {27'd0, v.cnt});
        chk("w0_first_err", {28'd0, first0}, {28'd0, v.first});
    endtask

    initial begin
        int nd;
        //             model      expected   table      pass  cnt    vld   first
        vecs[0] = '{16'h212F, 16'h212F, 16'h212F, 1'b1, 5'd0,  1'b0, 4'd0};
        vecs[1] = '{16'h212F, 16'h212E, 16'h212F, 1'b0, 5'd1,  1'b1, 4'd0};
        vecs[2] = '{16'h0000, 16'hFFFF, 16'h0000, 1'b0, 5'd16, 1'b1, 4'd0};
        vecs[3] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 5'd16, 1'b1, 4'd0};
        vecs[4] = '{16'h212F, 16'h292F, 16'h212F, 1'b0, 5'd1,  1'b1, 4'd11};
        vecs[5] = '{16'h00F0, 16'h0000, 16'h00F0, 1'b0, 5'd4,  1'b1, 4'd4};
        vecs[6] = '{16'h8000, 16'h0000, 16'h8000, 1'b0, 5'd1,  1'b1, 4'd15};

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_done", {31'd0, done1}, 32'd0);
        chk("rst_abcd", {28'd0, a1, b1, c1, d1}, 32'd0);
        chk("rst_table", {16'd0, tbl1}, 32'd0);
        chk("rst_pass", {31'd0, pass1}, 32'd0);
        chk("rst_err_count", {27'd0, cnt1}, 32'd0);
        chk("rst_err_valid", {31'd0, vld1}, 32'd0);
        chk("rst_first_err", {28'd0, first1}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_scan(vecs[i], 1'b0);

        // Reset in the middle of a failing scan aborts it without a done pulse.
        @(negedge clk);
        model = 16'h0000; expected = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_abort_errors_seen", {31'd0, (cnt1 != 5'd0)}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {30'd0, busy1, busy0}, 32'd0);
        chk("abort_abcd", {28'd0, a1, b1, c1, d1}, 32'd0);
        chk("abort_err_count", {27'd0, cnt1}, 32'd0);
        chk("abort_err_valid", {31'd0, vld1}, 32'd0);
        chk("abort_table", {16'd0, tbl1}, 32'd0);
        nd = 0;
        repeat (50) begin
            @(negedge clk);
            if (done1 || done0) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        run_scan(vecs[0], 1'b0);

        // Start pulses while busy and expected flipping mid-scan are ignored.
        run_scan(vecs[0], 1'b1);
        run_scan(vecs[4], 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
